// File: rtl/pifo_tree_sched.sv
// Front-end scheduler for the 4-ary PIFO tree.
// Arbitrates NREQ pushers and one popper onto the single root port pair.
module pifo_tree_sched #(
    parameter int PTW     = 16,
    parameter int MTW     = 32,
    parameter int CTW     = 11,
    parameter int CAP     = 1365,
    parameter int NREQ    = 4,
    parameter int OP_GAP  = 2,
    parameter int POP_LAT = 1
) (
    input  logic                      i_clk,
    input  logic                      i_arst_n,
    input  logic [NREQ-1:0]           i_req_push,
    input  logic [NREQ*(MTW+PTW)-1:0] i_req_data,
    output logic [NREQ-1:0]           o_req_ack,
    input  logic                      i_pop_req,
    output logic                      o_pop_ack,
    output logic                      o_pop_valid,
    output logic [MTW+PTW-1:0]        o_pop_data,
    output logic                      o_push,
    output logic [MTW+PTW-1:0]        o_push_data,
    output logic                      o_pop,
    input  logic [MTW+PTW-1:0]        i_pop_data,
    output logic [CTW-1:0]            o_count,
    output logic                      o_full,
    output logic                      o_empty
);

    localparam int EW = MTW + PTW;
    localparam int RW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int GW = OP_GAP > 1 ? $clog2(OP_GAP) : 1;

    typedef enum logic {
        OP_POP  = 1'b0,
        OP_PUSH = 1'b1
    } op_e;

    logic [RW-1:0]      rr_q;
    logic [GW-1:0]      gap_q;
    op_e                last_q;
    logic [POP_LAT-1:0] ret_q;

    logic [NREQ-1:0] req_m;
    logic [RW-1:0]   win;
    logic            found;
    logic            slot;
    logic            push_el;
    logic            pop_el;
    logic            do_push;
    logic            do_pop;

    // A request being acked this cycle is not yet dropped; never re-grant it.
    always_comb begin
        req_m = i_req_push & ~o_req_ack;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_m[(int'(rr_q) + i) % NREQ]) begin
                found = 1'b1;
                win   = RW'((int'(rr_q) + i) % NREQ);
            end
        end
    end

    assign slot    = (gap_q == '0);
    assign push_el = (|req_m) && !o_full;
    assign pop_el  = i_pop_req && !o_pop_ack && !o_empty;
    assign do_push = slot && push_el && (!pop_el || last_q == OP_POP);
    assign do_pop  = slot && pop_el && (!push_el || last_q == OP_PUSH);

    assign o_full  = (o_count == CTW'(CAP));
    assign o_empty = (o_count == '0);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            rr_q        <= '0;
            gap_q       <= '0;
            last_q      <= OP_POP;
            ret_q       <= '0;
            o_req_ack   <= '0;
            o_pop_ack   <= 1'b0;
            o_pop_valid <= 1'b0;
            o_pop_data  <= '0;
            o_push      <= 1'b0;
            o_push_data <= '0;
            o_pop       <= 1'b0;
            o_count     <= '0;
        end else begin
            o_push    <= do_push;
            o_pop     <= do_pop;
            o_pop_ack <= do_pop;
            o_req_ack <= do_push ? (NREQ'(1) << win) : '0;
            if (do_push) begin
                o_push_data <= i_req_data[int'(win)*EW +: EW];
                rr_q        <= (win == RW'(NREQ - 1)) ? '0 : win + 1'b1;
            end
            if (do_push || do_pop) begin
                gap_q  <= GW'(OP_GAP - 1);
                last_q <= do_push ? OP_PUSH : OP_POP;
            end else if (!slot) begin
                gap_q <= gap_q - 1'b1;
            end
            // Count moves with the issue so the next slot sees the new level.
            if (do_push) begin
                o_count <= o_count + 1'b1;
            end else if (do_pop) begin
                o_count <= o_count - 1'b1;
            end
            ret_q       <= POP_LAT'({ret_q, o_pop});
            o_pop_valid <= ret_q[POP_LAT-1];
            if (ret_q[POP_LAT-1]) begin
                o_pop_data <= i_pop_data;
            end
        end
    end

endmodule

// File: tb/tb_pifo_tree_sched.sv
// Scoreboard bench for pifo_tree_sched.
// Expected pushes/pops are queued by stimulus; a monitor checks DUT strobes.
module tb_pifo_tree_sched;

    localparam int PTW     = 16;
    localparam int MTW     = 32;
    localparam int CTW     = 11;
    localparam int CAP     = 1365;
    localparam int NREQ    = 4;
    localparam int OP_GAP  = 2;
    localparam int POP_LAT = 1;
    localparam int EW      = MTW + PTW;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_push = '0;
    logic [NREQ*EW-1:0]   req_data = '0;
    logic [NREQ-1:0]      req_ack;
    logic                 pop_req = 1'b0;
    logic                 pop_ack;
    logic                 pop_valid;
    logic [EW-1:0]        pop_data;
    logic                 push;
    logic [EW-1:0]        push_data;
    logic                 pop;
    logic [EW-1:0]        tree_data = '0;
    logic [CTW-1:0]       count;
    logic                 full;
    logic                 empty;

    pifo_tree_sched #(
        .PTW(PTW), .MTW(MTW), .CTW(CTW), .CAP(CAP),
        .NREQ(NREQ), .OP_GAP(OP_GAP), .POP_LAT(POP_LAT)
    ) dut (
        .i_clk(clk),
        .i_arst_n(rst_n),
        .i_req_push(req_push),
        .i_req_data(req_data),
        .o_req_ack(req_ack),
        .i_pop_req(pop_req),
        .o_pop_ack(pop_ack),
        .o_pop_valid(pop_valid),
        .o_pop_data(pop_data),
        .o_push(push),
        .o_push_data(push_data),
        .o_pop(pop),
        .i_pop_data(tree_data),
        .o_count(count),
        .o_full(full),
        .o_empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            idx;
        logic [EW-1:0] data;
    } push_t;

    typedef struct {
        logic [EW-1:0] data;
        int            due;
    } pop_t;

    push_t exp_push[$];
    pop_t  exp_pop[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    pop_seq = 0;

    always @(posedge clk) cyc++;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic timeout(string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: no response within bound (cycle %0d)", name, cyc);
    endtask

    // Tree model: answers each root pop with a fresh pattern.
    always @(negedge clk) begin
        if (rst_n && pop) begin
            pop_t p;
            pop_seq++;
            p.data    = {32'hC0DE_0000 + 32'(pop_seq), 16'(pop_seq * 3 + 7)};
            p.due     = cyc + POP_LAT + 1;
            tree_data = p.data;
            exp_pop.push_back(p);
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (push || req_ack != '0) begin
                if (exp_push.size() == 0) begin
                    check("unexpected_push", {push, req_ack}, 0);
                end else begin
                    push_t e;
                    e = exp_push.pop_front();
                    check("push_strobe", push, 1);
                    check("push_ack", req_ack, NREQ'(1) << e.idx);
                    check("push_data", push_data, e.data);
                    check("push_pop_excl", pop, 0);
                end
            end
            if (pop || pop_ack) begin
                check("pop_ack_align", {pop, pop_ack}, 2'b11);
            end
            if (pop_valid) begin
                if (exp_pop.size() == 0) begin
                    check("unexpected_pop_valid", pop_valid, 0);
                end else begin
                    pop_t p;
                    p = exp_pop.pop_front();
                    check("pop_data", pop_data, p.data);
                    check("pop_latency", cyc, p.due);
                end
            end
        end
    end

    task automatic set_data(int k, logic [EW-1:0] d);
        req_data[k*EW +: EW] = d;
    endtask

    task automatic expect_push(int k, logic [EW-1:0] d);
        push_t e;
        e.idx  = k;
        e.data = d;
        exp_push.push_back(e);
    endtask

    task automatic chk_reset_vals();
        check("rst_strobes", {req_ack, pop_ack, pop_valid, push, pop, full}, 0);
        check("rst_pop_data", pop_data, 0);
        check("rst_push_data", push_data, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req_push = '0;
        pop_req  = 1'b0;
        exp_push.delete();
        exp_pop.delete();
        @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_push(output int idx);
        idx = -1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_ack != '0) begin
                for (int b = 0; b < NREQ; b++) begin
                    if (req_ack[b]) idx = b;
                end
                return;
            end
        end
        timeout("push_wait");
    endtask

    task automatic wait_pop_ack();
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (pop_ack) return;
        end
        timeout("pop_wait");
    endtask

    initial begin
        int            w;
        int            last_cyc;
        logic [EW-1:0] d;
        int            pri[3];

        pri[0] = 5;
        pri[1] = 3;
        pri[2] = 9;

        // Reset, idle, pop while empty
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_quiet", {push, pop, pop_valid, req_ack, pop_ack}, 0);
        end
        pop_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("empty_pop_blocked", {pop, pop_ack, empty}, 3'b001);
        end
        pop_req = 1'b0;

        // Single requester 1, priorities 5,3,9
        last_cyc = 0;
        for (int k = 0; k < 3; k++) begin
            d = {32'h0000_1000 + 32'(k), 16'(pri[k])};
            set_data(1, d);
            expect_push(1, d);
            req_push[1] = 1'b1;
            wait_push(w);
            req_push[1] = 1'b0;
            if (k > 0) check("push_spacing", cyc - last_cyc, OP_GAP);
            last_cyc = cyc;
            @(negedge clk);
            check("single_count", count, k + 1);
            req_push[1] = (k < 2);
        end
        req_push = '0;

        // Four requesters held: round-robin from pointer 0
        do_reset();
        for (int k = 0; k < NREQ; k++) set_data(k, {32'hD000_0000 + 32'(k), 16'(k * 7 + 1)});
        for (int i = 0; i < 8; i++) expect_push(i % NREQ, {32'hD000_0000 + 32'(i % NREQ), 16'((i % NREQ) * 7 + 1)});
        req_push = '1;
        for (int i = 0; i < 8; i++) begin
            wait_push(w);
            check("rr_order", w, i % NREQ);
        end
        req_push = '0;
        repeat (3) @(negedge clk);
        check("rr_count", count, 8);

        // Alternation: count=2, last op POP
        do_reset();
        d = 48'hAAAA_0002_0011;
        set_data(2, d);
        for (int i = 0; i < 3; i++) expect_push(2, d);
        req_push[2] = 1'b1;
        for (int i = 0; i < 3; i++) wait_push(w);
        req_push[2] = 1'b0;
        pop_req = 1'b1;
        wait_pop_ack();
        pop_req = 1'b0;
        repeat (4) @(negedge clk);
        check("alt_setup_count", count, 2);
        d = 48'hBBBB_0003_0022;
        set_data(3, d);
        expect_push(3, d);
        expect_push(3, d);
        req_push[3] = 1'b1;
        pop_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                seen = push || pop;
            end
            if (!seen) timeout("alt_op_wait");
            else check("alt_op_is_push", push, (i % 2) == 0);
        end
        req_push[3] = 1'b0;
        pop_req = 1'b0;
        repeat (4) @(negedge clk);
        check("alt_count", count, 2);

        // Fill to CAP, then one pop frees exactly one slot
        do_reset();
        d = 48'hF111_F000_0042;
        set_data(0, d);
        req_push[0] = 1'b1;
        for (int i = 0; i < CAP; i++) begin
            expect_push(0, d);
            wait_push(w);
            if (w < 0) break;
        end
        repeat (2) @(negedge clk);
        check("fill_full", full, 1);
        check("fill_count", count, CAP);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("full_no_ack", req_ack, 0);
        end
        pop_req = 1'b1;
        expect_push(0, d);
        wait_pop_ack();
        pop_req = 1'b0;
        check("pop_clears_full", full, 0);
        wait_push(w);
        req_push[0] = 1'b0;
        check("refill_ack_idx", w, 0);
        @(negedge clk);
        check("refill_full", full, 1);

        // Reset one cycle after o_pop: in-flight return is dropped
        pop_req = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                seen = pop;
            end
            if (!seen) timeout("midop_pop_wait");
        end
        pop_req = 1'b0;
        @(negedge clk);
        do_reset();
        repeat (6) @(negedge clk);
        check("post_rst_count", count, 0);
        check("post_rst_empty", empty, 1);

        check("push_queue_drained", exp_push.size(), 0);
        check("pop_queue_drained", exp_pop.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation bound reached");
        $fatal(1);
    end

endmodule
